// File: rtl/dll_rx_seq_check.sv
// DLL receive path: sequence/LCRC check, store-and-forward beat buffer toward TL, ACK/NAK DLLP requests.
// Optional receive statistics counters are enabled with `define DLL_RX_STATS_EN.
`timescale 1ns/1ps
module dll_rx_seq_check #(
  parameter int PIPE_DATA_WIDTH = 256,
  parameter int BUF_DEPTH_LG2   = 3,
  parameter int ACK_LATENCY     = 32
) (
  input  logic                       sclk,
  input  logic                       srst_n,
  input  logic [PIPE_DATA_WIDTH-1:0] rx_data_i,
  input  logic                       rx_valid_i,
  input  logic                       rx_sop_i,
  input  logic                       rx_eop_i,
  input  logic [11:0]                rx_seq_i,
  input  logic                       rx_lcrc_ok_i,
  output logic [PIPE_DATA_WIDTH-1:0] dll2tl_data_o,
  output logic [2:0]                 dll2tl_data_en_o,
  output logic                       dllp_req_o,
  output logic                       dllp_nak_o,
  output logic [11:0]                dllp_seq_o,
  input  logic                       dllp_ack_i
`ifdef DLL_RX_STATS_EN
  ,
  output logic [15:0]                stat_good_o,
  output logic [15:0]                stat_dup_o,
  output logic [15:0]                stat_bad_o
`endif
);
  localparam int DEPTH = 1 << BUF_DEPTH_LG2;
  localparam int TW    = $clog2(ACK_LATENCY) + 1;
  localparam logic [TW-1:0] TMR_MAX = TW'(ACK_LATENCY - 1);
  localparam logic [2:0] EN_IDLE = 3'd0, EN_P_HDR = 3'd1, EN_P_DATA = 3'd2, EN_NP_HDR = 3'd3,
                         EN_CPL_HDR = 3'd5, EN_CPL_DATA = 3'd6;

  typedef logic [BUF_DEPTH_LG2-1:0] ptr_t;
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;
  typedef enum logic [1:0] {C_P, C_NP, C_CPL, C_DROP} cls_t;

  function automatic cls_t hdr_class(input logic fmt1, input logic [4:0] typ);
    if (typ == 5'b00000) return fmt1 ? C_P : C_NP;
    else if (typ == 5'b01010) return C_CPL;
    else return C_DROP;
  endfunction

  logic [PIPE_DATA_WIDTH:0] mem [DEPTH];
  ptr_t        wr_tmp, wr_cmt, rd, wp;
  logic        tlp_open, ovf_lat, beat_ok, ovf_now, cur_ovf;
  logic [11:0] seq_lat, next_seq, cur_seq, seq_gap;
  logic        eop_evt, good_evt, dup_evt, bad_evt;

  // Receive side: classify the TLP as it closes; a new sop always restarts at the commit point.
  always_comb begin
    wp       = rx_sop_i ? wr_cmt : wr_tmp;
    beat_ok  = rx_valid_i & (rx_sop_i | tlp_open);
    ovf_now  = ptr_t'(wp + ptr_t'(1)) == rd;
    cur_seq  = rx_sop_i ? rx_seq_i : seq_lat;
    cur_ovf  = ovf_now | (~rx_sop_i & ovf_lat);
    seq_gap  = next_seq - cur_seq;
    eop_evt  = beat_ok & rx_eop_i;
    good_evt = eop_evt & rx_lcrc_ok_i & ~cur_ovf & (cur_seq == next_seq);
    dup_evt  = eop_evt & rx_lcrc_ok_i & ~cur_ovf & (seq_gap != 12'd0) & (seq_gap <= 12'd2048);
    bad_evt  = eop_evt & ~good_evt & ~dup_evt;
  end

  always_ff @(posedge sclk) begin
    if (beat_ok && !ovf_now) mem[wp] <= {rx_eop_i, rx_data_i};
  end

  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      wr_tmp   <= '0;
      wr_cmt   <= '0;
      tlp_open <= 1'b0;
      ovf_lat  <= 1'b0;
      seq_lat  <= '0;
      next_seq <= '0;
    end else if (beat_ok) begin
      if (rx_sop_i) seq_lat <= rx_seq_i;
      ovf_lat <= cur_ovf;
      if (rx_eop_i) begin
        tlp_open <= 1'b0;
        if (good_evt) begin
          wr_cmt   <= wp + ptr_t'(1);
          wr_tmp   <= wp + ptr_t'(1);
          next_seq <= next_seq + 12'd1;
        end else begin
          wr_tmp <= wr_cmt;
        end
      end else begin
        tlp_open <= 1'b1;
        wr_tmp   <= ovf_now ? wp : wp + ptr_t'(1);
      end
    end
  end

  // Drain: one committed beat per cycle, header decoded into the TL request code.
  state_t st, st_nx;
  cls_t   cls, cls_nx;
  logic [PIPE_DATA_WIDTH:0] rd_ent;
  logic       avail;
  logic [2:0] en_nx;

  always_ff @(posedge sclk) begin
    if (!srst_n) st <= S_IDLE;
    else         st <= st_nx;
  end

  always_comb begin
    rd_ent = mem[rd];
    avail  = rd != wr_cmt;
    st_nx  = st;
    cls_nx = cls;
    en_nx  = EN_IDLE;
    if (avail) begin
      if (st == S_DATA) begin
        case (cls)
          C_P:     en_nx = EN_P_DATA;
          C_CPL:   en_nx = EN_CPL_DATA;
          default: en_nx = EN_IDLE;
        endcase
      end else begin
        cls_nx = hdr_class(rd_ent[30], rd_ent[28:24]);
        case (cls_nx)
          C_P:     en_nx = EN_P_HDR;
          C_NP:    en_nx = EN_NP_HDR;
          C_CPL:   en_nx = EN_CPL_HDR;
          default: en_nx = EN_IDLE;
        endcase
      end
      if (rd_ent[PIPE_DATA_WIDTH]) st_nx = (ptr_t'(rd + ptr_t'(1)) != wr_cmt) ? S_HDR : S_IDLE;
      else                         st_nx = S_DATA;
    end else if (st != S_DATA) begin
      st_nx = S_IDLE;
    end
  end

  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      cls              <= C_DROP;
      rd               <= '0;
      dll2tl_data_en_o <= EN_IDLE;
      dll2tl_data_o    <= '0;
    end else begin
      cls              <= cls_nx;
      dll2tl_data_en_o <= en_nx;
      if (avail) begin
        rd            <= rd + ptr_t'(1);
        dll2tl_data_o <= rd_ent[PIPE_DATA_WIDTH-1:0];
      end
    end
  end

  // ACK/NAK scheduling: NAK beats any ACK; a request is frozen until the TX mux takes it.
  logic        req_q, nak_q, ack_pend, nak_sched, nak_pend, dup_pend;
  logic        hs, want_nak, want_ack, issue_nak, issue_ack, tmr_clr;
  logic [11:0] dseq_q, ack_seq;
  logic [TW-1:0] timer;

  always_comb begin
    hs        = req_q & dllp_ack_i;
    ack_seq   = next_seq - 12'd1;
    want_nak  = nak_pend | (bad_evt & ~nak_sched);
    want_ack  = dup_pend | dup_evt | (ack_pend & (timer == TMR_MAX));
    issue_nak = ~req_q & want_nak;
    issue_ack = ~req_q & ~want_nak & want_ack;
    tmr_clr   = ~ack_pend | issue_ack | issue_nak | (good_evt & hs);
  end

  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      req_q     <= 1'b0;
      nak_q     <= 1'b0;
      dseq_q    <= '0;
      ack_pend  <= 1'b0;
      nak_sched <= 1'b0;
      nak_pend  <= 1'b0;
      dup_pend  <= 1'b0;
      timer     <= '0;
    end else begin
      if (issue_nak || issue_ack) begin
        req_q  <= 1'b1;
        nak_q  <= issue_nak;
        dseq_q <= ack_seq;
      end else if (hs) begin
        req_q <= 1'b0;
      end
      if (bad_evt)       nak_sched <= 1'b1;
      else if (good_evt) nak_sched <= 1'b0;
      if (issue_nak)                     nak_pend <= 1'b0;
      else if (bad_evt && !nak_sched)    nak_pend <= 1'b1;
      if (issue_nak || issue_ack) dup_pend <= 1'b0;
      else if (dup_evt)           dup_pend <= 1'b1;
      if (good_evt)                                        ack_pend <= 1'b1;
      else if (issue_nak || (hs && dseq_q == ack_seq))     ack_pend <= 1'b0;
      if (tmr_clr)               timer <= '0;
      else if (timer != TMR_MAX) timer <= timer + TW'(1);
    end
  end

  assign dllp_req_o = req_q;
  assign dllp_nak_o = nak_q;
  assign dllp_seq_o = dseq_q;

`ifdef DLL_RX_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      stat_good_o <= '0;
      stat_dup_o  <= '0;
      stat_bad_o  <= '0;
    end else begin
      if (good_evt) stat_good_o <= sat_inc(stat_good_o);
      if (dup_evt)  stat_dup_o  <= sat_inc(stat_dup_o);
      if (bad_evt)  stat_bad_o  <= sat_inc(stat_bad_o);
    end
  end
`endif
endmodule

// File: tb/tb_dll_rx_seq_check.sv
// Bench for dll_rx_seq_check: TLP vector table, TL-side scoreboard queue, DLLP handshake checks.
`timescale 1ns/1ps
module tb_dll_rx_seq_check;
  localparam int W  = 256;
  localparam int AL = 32;

  logic          sclk = 1'b0;
  logic          srst_n;
  logic [W-1:0]  rx_data_i;
  logic          rx_valid_i, rx_sop_i, rx_eop_i, rx_lcrc_ok_i, dllp_ack_i;
  logic [11:0]   rx_seq_i;
  logic [W-1:0]  dll2tl_data_o;
  logic [2:0]    dll2tl_data_en_o;
  logic          dllp_req_o, dllp_nak_o;
  logic [11:0]   dllp_seq_o;
`ifdef DLL_RX_STATS_EN
  logic [15:0]   stat_good_o, stat_dup_o, stat_bad_o;
`endif

  always #5 sclk = ~sclk;

  dll_rx_seq_check #(.PIPE_DATA_WIDTH(W), .BUF_DEPTH_LG2(3), .ACK_LATENCY(AL)) dut (
    .sclk(sclk), .srst_n(srst_n), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .rx_sop_i(rx_sop_i), .rx_eop_i(rx_eop_i), .rx_seq_i(rx_seq_i), .rx_lcrc_ok_i(rx_lcrc_ok_i),
    .dll2tl_data_o(dll2tl_data_o), .dll2tl_data_en_o(dll2tl_data_en_o),
    .dllp_req_o(dllp_req_o), .dllp_nak_o(dllp_nak_o), .dllp_seq_o(dllp_seq_o),
    .dllp_ack_i(dllp_ack_i)
`ifdef DLL_RX_STATS_EN
    , .stat_good_o(stat_good_o), .stat_dup_o(stat_dup_o), .stat_bad_o(stat_bad_o)
`endif
  );

  typedef struct packed { logic [2:0] en; logic [W-1:0] data; } exp_t;
  typedef struct {
    logic [7:0]  ft;    // header DW0[31:24] = {Fmt, Type}
    int          nb;
    logic [11:0] seq;
    bit          lcrc;
    bit          fwd;
    logic [2:0]  hen;
    logic [2:0]  den;
    int          dllp;  // 0 none, 1 coalesced ACK, 2 immediate ACK, 3 NAK
    logic [11:0] dseq;
    string       nm;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[16];
  int          checks = 0;
  int          errors = 0;
  logic [2:0]  s_en;
  logic [W-1:0] s_data;
  logic        s_req, s_nak;
  logic [11:0] s_seq;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Samples outputs mid-cycle and scores any TL beat, then moves past the next rising edge.
  task automatic step();
    exp_t e;
    @(negedge sclk);
    s_en = dll2tl_data_en_o; s_data = dll2tl_data_o;
    s_req = dllp_req_o; s_nak = dllp_nak_o; s_seq = dllp_seq_o;
    if (s_en != 3'd0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tl_unexpected: en=%0d, want no TL output", s_en);
      end else begin
        e = exp_q.pop_front();
        if (s_en !== e.en || s_data !== e.data) begin
          errors++;
          $display("FAIL tl_beat: en=%0d data=%h, want en=%0d data=%h", s_en, s_data, e.en, e.data);
        end
      end
    end
    @(posedge sclk); #1;
  endtask

  task automatic do_reset();
    srst_n = 1'b0; rx_valid_i = 1'b0; rx_sop_i = 1'b0; rx_eop_i = 1'b0;
    rx_seq_i = '0; rx_lcrc_ok_i = 1'b0; rx_data_i = '0; dllp_ack_i = 1'b0;
    repeat (3) step();
  endtask

  task automatic send_tlp(logic [7:0] ft, int nb, logic [11:0] seq, bit lcrc, bit fwd,
                          logic [2:0] hen, logic [2:0] den);
    logic [W-1:0] d;
    exp_t e;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < W/32; k++) d[k*32 +: 32] = $urandom();
      if (b == 0) d[31:24] = ft;
      rx_valid_i   = 1'b1;
      rx_sop_i     = (b == 0);
      rx_eop_i     = (b == nb - 1);
      rx_seq_i     = (b == 0) ? seq : 12'($urandom());
      rx_lcrc_ok_i = (b == nb - 1) ? lcrc : 1'($urandom());
      rx_data_i    = d;
      e.en   = (b == 0) ? hen : den;
      e.data = d;
      if (fwd && e.en != 3'd0) exp_q.push_back(e);
      step();
    end
    rx_valid_i = 1'b0; rx_sop_i = 1'b0; rx_eop_i = 1'b0; rx_lcrc_ok_i = 1'b0;
  endtask

  task automatic drain(string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 16) begin step(); n++; end
    check({nm, "_tl_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_dllp(string nm, bit nak, logic [11:0] seq, int bound);
    int n = 0;
    while (!s_req && n < bound) begin step(); n++; end
    checks++;
    if (!s_req) begin
      errors++;
      $display("FAIL %s: no DLLP request within %0d cycles", nm, bound);
      return;
    end
    if (s_nak !== nak || s_seq !== seq) begin
      errors++;
      $display("FAIL %s: nak=%0d seq=%0d, want nak=%0d seq=%0d", nm, s_nak, s_seq, nak, seq);
    end
    step();
    check({nm, "_held"}, {19'd0, s_req, s_nak, s_seq}, {19'd0, 1'b1, nak, seq});
    dllp_ack_i = 1'b1;
    step();
    dllp_ack_i = 1'b0;
  endtask

  task automatic expect_no_dllp(string nm, int n);
    bit seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      if (s_req) seen = 1'b1;
    end
    check({nm, "_no_dllp"}, 32'(seen), 32'd0);
  endtask

  task automatic run_vec(int i);
    send_tlp(vecs[i].ft, vecs[i].nb, vecs[i].seq, vecs[i].lcrc, vecs[i].fwd, vecs[i].hen, vecs[i].den);
    drain(vecs[i].nm);
    case (vecs[i].dllp)
      1:       wait_dllp(vecs[i].nm, 1'b0, vecs[i].dseq, AL + 12);
      2:       wait_dllp(vecs[i].nm, 1'b0, vecs[i].dseq, 4);
      3:       wait_dllp(vecs[i].nm, 1'b1, vecs[i].dseq, 4);
      default: expect_no_dllp(vecs[i].nm, AL + 13);
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //          ft     nb  seq      lcrc  fwd   hen   den   dllp dseq
    vecs[0]  = '{8'h40, 2, 12'd0,    1'b1, 1'b1, 3'd1, 3'd2, 1, 12'd0,    "mwr_s0"};
    vecs[1]  = '{8'h40, 1, 12'd2,    1'b1, 1'b1, 3'd1, 3'd0, 1, 12'd2,    "mwr_hdr_only_s2"};
    vecs[2]  = '{8'h40, 3, 12'd3,    1'b1, 1'b1, 3'd1, 3'd2, 1, 12'd3,    "mwr_3beat_s3"};
    vecs[3]  = '{8'h0A, 1, 12'd4,    1'b1, 1'b1, 3'd5, 3'd0, 1, 12'd4,    "cpl_s4"};
    vecs[4]  = '{8'h40, 2, 12'd3,    1'b1, 1'b0, 3'd0, 3'd0, 2, 12'd4,    "dup_s3"};
    vecs[5]  = '{8'h40, 2, 12'd5,    1'b0, 1'b0, 3'd0, 3'd0, 3, 12'd4,    "lcrc_bad_s5"};
    vecs[6]  = '{8'h40, 2, 12'd6,    1'b1, 1'b0, 3'd0, 3'd0, 0, 12'd0,    "ahead_s6_nak_sched"};
    vecs[7]  = '{8'h40, 2, 12'd5,    1'b1, 1'b1, 3'd1, 3'd2, 1, 12'd5,    "replay_s5"};
    vecs[8]  = '{8'h30, 2, 12'd6,    1'b1, 1'b0, 3'd0, 3'd0, 1, 12'd6,    "msg_dropped_s6"};
    vecs[9]  = '{8'h00, 2, 12'd7,    1'b1, 1'b1, 3'd3, 3'd0, 1, 12'd7,    "mrd_extra_beat_s7"};
    vecs[10] = '{8'h40, 1, 12'd20,   1'b1, 1'b0, 3'd0, 3'd0, 3, 12'd7,    "ahead_s20"};
    vecs[11] = '{8'h4A, 2, 12'd8,    1'b1, 1'b1, 3'd5, 3'd6, 1, 12'd8,    "cpld_s8"};
    vecs[12] = '{8'h40, 2, 12'd4095, 1'b1, 1'b1, 3'd1, 3'd2, 1, 12'd4095, "mwr_s4095"};
    vecs[13] = '{8'h40, 2, 12'd0,    1'b1, 1'b1, 3'd1, 3'd2, 1, 12'd0,    "wrap_s0"};
    vecs[14] = '{8'h40, 9, 12'd1,    1'b1, 1'b0, 3'd0, 3'd0, 3, 12'd0,    "overflow_9beat"};
    vecs[15] = '{8'h40, 2, 12'd1,    1'b1, 1'b1, 3'd1, 3'd2, 1, 12'd1,    "after_overflow_s1"};

    do_reset();
    check("rst_en",   32'(s_en), 32'd0);
    check("rst_data", 32'(s_data != '0), 32'd0);
    check("rst_req",  32'(s_req), 32'd0);
    check("rst_nak",  32'(s_nak), 32'd0);
    check("rst_seq",  32'(s_seq), 32'd0);
    srst_n = 1'b1;
    step();
    run_vec(0);

    // MRd then CplD back to back: both forwarded, one coalesced ACK for the later one.
    do_reset();
    srst_n = 1'b1;
    step();
    send_tlp(8'h00, 1, 12'd0, 1'b1, 1'b1, 3'd3, 3'd0);
    send_tlp(8'h4A, 2, 12'd1, 1'b1, 1'b1, 3'd5, 3'd6);
    drain("coal");
    wait_dllp("coal_ack", 1'b0, 12'd1, AL + 12);
    expect_no_dllp("coal_single", AL + 13);

    for (int i = 1; i <= 11; i++) run_vec(i);

    // Walk NEXT_RCV_SEQ up to 4095 with dropped-type TLPs, accepting every DLLP on the way.
    do_reset();
    srst_n = 1'b1;
    step();
    dllp_ack_i = 1'b1;
    for (int s = 0; s < 4095; s++) begin
      rx_valid_i = 1'b1; rx_sop_i = 1'b1; rx_eop_i = 1'b1; rx_lcrc_ok_i = 1'b1;
      rx_seq_i = 12'(s);
      rx_data_i = '0;
      rx_data_i[31:24] = 8'h30;
      step();
    end
    rx_valid_i = 1'b0; rx_sop_i = 1'b0; rx_eop_i = 1'b0; rx_lcrc_ok_i = 1'b0;
    repeat (AL + 30) step();
    dllp_ack_i = 1'b0;
    expect_no_dllp("wrap_quiet", AL + 13);

    for (int i = 12; i <= 15; i++) run_vec(i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
